ysyx_23060077_riscv_axi_rd_arbiter: RTL and testbench
=====================================================

# ysyx_23060077_riscv_axi_rd_arbiter

Two-master, one-slave AXI-lite read-channel arbiter between the instruction-fetch unit (master 0) and the load/store unit (master 1). It shares the single read port of the DPI-backed AXI SRAM slave between them. Only one read transaction is outstanding at a time, and the grant is held from address acceptance until the read-data handshake completes. The arbiter latches the address, so the slave sees a stable request, and uses round-robin priority to keep either master from starving.

## Interface
Parameters:
- ADDR_W, 32, address width (matches `AXI_ADDR_WIDTH`)
- DATA_W, 32, read data width
- PORT_W, 3, AR port/prot width
- RESP_W, 2, response width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset_n  in  1  reset, synchronous, active-low
- m0_ar_valid_i  in  1  master 0 read-address valid
- m0_ar_ready_o  out  1  master 0 address accepted
- m0_ar_addr_i  in  ADDR_W  master 0 read address
- m0_ar_port_i  in  PORT_W  master 0 port/prot
- m0_r_valid_o  out  1  master 0 read data valid
- m0_r_ready_i  in  1  master 0 read data ready
- m0_r_data_o  out  DATA_W  master 0 read data
- m0_r_resp_o  out  RESP_W  master 0 read response
- m1_ar_valid_i, m1_ar_ready_o, m1_ar_addr_i, m1_ar_port_i, m1_r_valid_o, m1_r_ready_i, m1_r_data_o, m1_r_resp_o: same directions, widths and meanings as the m0 ports, for master 1
- s_ar_valid_o  out  1  slave read-address valid
- s_ar_ready_i  in  1  slave address accepted
- s_ar_addr_o  out  ADDR_W  latched address to slave
- s_ar_port_o  out  PORT_W  latched port to slave
- s_r_valid_i  in  1  slave read data valid
- s_r_ready_o  out  1  slave read data ready
- s_r_data_i  in  DATA_W  slave read data
- s_r_resp_i  in  RESP_W  slave read response

## Operation
- State machine (2-bit): IDLE, ADDR, DATA. Registers: state, gnt (1 bit), last_gnt (1 bit), addr_q, port_q.
- IDLE:
  - If only one master has ar_valid high, that master wins.
  - If both are high, the master != last_gnt wins.
  - The winner's mX_ar_ready_o is asserted combinationally in the same cycle.
  - Next edge: addr_q/port_q capture the winner's addr/port, gnt = winner, last_gnt = winner, state -> ADDR.
  - With no request, state stays IDLE and all readies stay 0.
- ADDR:
  - s_ar_valid_o = 1; s_ar_addr_o = addr_q; s_ar_port_o = port_q.
  - On s_ar_valid_o && s_ar_ready_i: state -> DATA.
- DATA:
  - s_r_ready_o = r_ready_i of the granted master.
  - The granted master's r_valid_o = s_r_valid_i, and its r_data/r_resp = s_r_data_i/s_r_resp_i.
  - On s_r_valid_i && s_r_ready_o: state -> IDLE.
- Non-granted master, and any master outside DATA: r_valid_o = 0, r_data_o = 0, r_resp_o = 0.
- ar_ready_o is never asserted outside IDLE. A master raising ar_valid during ADDR/DATA waits; it is not dropped.
- s_ar_addr_o/s_ar_port_o show addr_q/port_q in every state. s_ar_valid_o is high only in ADDR.
- Response codes pass through unmodified; the arbiter generates no errors.

## Timing
- Reset (areset_n low at an edge): state = IDLE, gnt = 0, last_gnt = 1 (master 0 wins the first tie), addr_q = 0, port_q = 0.
- All outputs are 0 during and immediately after reset.
- Reset mid-transaction: everything is abandoned and returns to IDLE next edge. No R beat is forwarded afterwards.
- Latency:
  - A request accepted in cycle N gives s_ar_valid_o = 1 in cycle N+1.
  - An R beat is forwarded combinationally, with zero added latency.
  - After the R handshake in cycle M, state is IDLE in cycle M+1, and a new grant is possible in M+1.
  - Minimum occupancy is 3 cycles per transaction (IDLE, ADDR, DATA).
- Handshake rules:
  - mX_ar_ready_o depends combinationally only on state, both ar_valid inputs and last_gnt.
  - s_r_ready_o and mX_r_valid_o have combinational paths from the master and slave respectively. This is acceptable because the slave registers its own valid.
- Simultaneous events:
  - Both ar_valid rise in the same IDLE cycle: exactly one ar_ready is high.
  - Back-to-back ties alternate strictly 0,1,0,1.
- Stall: a slave holding s_ar_ready_i low keeps ADDR indefinitely; a master holding r_ready low keeps DATA indefinitely. Neither is subject to a timeout.

## Test plan
- Reset, then single read: m0 requests addr 0x8000_0000 with no contention -> m0_ar_ready_o high in cycle 0, s_ar_valid_o/s_ar_addr_o = 0x8000_0000 in cycle 1; slave returns 0xDEADBEEF, resp 0 -> m0_r_data_o = 0xDEADBEEF with m0_r_valid_o high; m1_r_valid_o stays 0 throughout.
- Tie after reset: m0 and m1 both valid in the same cycle -> m0 granted first; m1 granted next, in the IDLE cycle after m0's R handshake; 4 further continuous ties grant m0,m1,m0,m1 (4 further grants, strict alternation).
- Late requester: m1 raises ar_valid while m0's transaction is in DATA -> m1_ar_ready_o stays 0 until the IDLE cycle after m0's R handshake, then pulses exactly once; s_ar_addr_o carries m1's address, not m0's.
- Backpressure: slave holds s_ar_ready_i low 5 cycles, then the granted master holds r_ready low 3 cycles after s_r_valid_i -> state holds in ADDR 5+1 cycles, s_r_ready_o tracks master r_ready, exactly one R beat delivered.
- Response pass-through: slave returns resp 2'b10, data 0x1234 for m1 -> m1_r_resp_o = 2'b10, m1_r_data_o = 0x1234; m0 outputs remain 0.
- Reset mid-op: areset_n asserted while in ADDR or DATA -> next cycle all outputs 0, state IDLE; the following tie grants m0.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter: round-robin grant, latched address,
// single outstanding read with the grant held until the R handshake completes.
module ysyx_23060077_riscv_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PORT_W = 3,
    parameter int RESP_W = 2
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              m0_ar_valid_i,
    output logic              m0_ar_ready_o,
    input  logic [ADDR_W-1:0] m0_ar_addr_i,
    input  logic [PORT_W-1:0] m0_ar_port_i,
    output logic              m0_r_valid_o,
    input  logic              m0_r_ready_i,
    output logic [DATA_W-1:0] m0_r_data_o,
    output logic [RESP_W-1:0] m0_r_resp_o,
    input  logic              m1_ar_valid_i,
    output logic              m1_ar_ready_o,
    input  logic [ADDR_W-1:0] m1_ar_addr_i,
    input  logic [PORT_W-1:0] m1_ar_port_i,
    output logic              m1_r_valid_o,
    input  logic              m1_r_ready_i,
    output logic [DATA_W-1:0] m1_r_data_o,
    output logic [RESP_W-1:0] m1_r_resp_o,
    output logic              s_ar_valid_o,
    input  logic              s_ar_ready_i,
    output logic [ADDR_W-1:0] s_ar_addr_o,
    output logic [PORT_W-1:0] s_ar_port_o,
    input  logic              s_r_valid_i,
    output logic              s_r_ready_o,
    input  logic [DATA_W-1:0] s_r_data_i,
    input  logic [RESP_W-1:0] s_r_resp_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              gnt_r;
    logic              last_gnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [PORT_W-1:0] port_r;
    logic              req_s;
    logic              win_s;
    logic              gnt_r_ready_s;

    // Round-robin winner: on a tie the master not served last wins
    always_comb begin
        req_s = m0_ar_valid_i | m1_ar_valid_i;
        if (m0_ar_valid_i && m1_ar_valid_i) begin
            win_s = ~last_gnt_r;
        end else if (m1_ar_valid_i) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        gnt_r_ready_s = gnt_r ? m1_r_ready_i : m0_r_ready_i;
    end

    // State, grant and latched request registers
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= 1'b0;
            last_gnt_r <= 1'b1;
            addr_r     <= {ADDR_W{1'b0}};
            port_r     <= {PORT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE && req_s) begin
                gnt_r      <= win_s;
                last_gnt_r <= win_s;
                addr_r     <= win_s ? m1_ar_addr_i : m0_ar_addr_i;
                port_r     <= win_s ? m1_ar_port_i : m0_ar_port_i;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) state_nxt_s = ST_ADDR;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (s_ar_ready_i) state_nxt_s = ST_DATA;
                else              state_nxt_s = ST_ADDR;
            end
            ST_DATA: begin
                if (s_r_valid_i && gnt_r_ready_s) state_nxt_s = ST_IDLE;
                else                              state_nxt_s = ST_DATA;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted
    always_comb begin
        m0_ar_ready_o = 1'b0;
        m1_ar_ready_o = 1'b0;
        m0_r_valid_o  = 1'b0;
        m1_r_valid_o  = 1'b0;
        m0_r_data_o   = {DATA_W{1'b0}};
        m1_r_data_o   = {DATA_W{1'b0}};
        m0_r_resp_o   = {RESP_W{1'b0}};
        m1_r_resp_o   = {RESP_W{1'b0}};
        s_ar_valid_o  = 1'b0;
        s_ar_addr_o   = {ADDR_W{1'b0}};
        s_ar_port_o   = {PORT_W{1'b0}};
        s_r_ready_o   = 1'b0;
        if (areset_n) begin
            s_ar_addr_o = addr_r;
            s_ar_port_o = port_r;
            case (state_r)
                ST_IDLE: begin
                    m0_ar_ready_o = req_s & ~win_s;
                    m1_ar_ready_o = req_s & win_s;
                end
                ST_ADDR: s_ar_valid_o = 1'b1;
                ST_DATA: begin
                    s_r_ready_o = gnt_r_ready_s;
                    if (gnt_r) begin
                        m1_r_valid_o = s_r_valid_i;
                        m1_r_data_o  = s_r_data_i;
                        m1_r_resp_o  = s_r_resp_i;
                    end else begin
                        m0_r_valid_o = s_r_valid_i;
                        m0_r_data_o  = s_r_data_i;
                        m0_r_resp_o  = s_r_resp_i;
                    end
                end
                default: s_ar_valid_o = 1'b0;
            endcase
        end else begin
            s_ar_valid_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_rd_arbiter.sv
// Directed bench for the read arbiter; expected R beats queued when the slave drives them.
module tb_ysyx_23060077_riscv_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        m0_ar_valid, m0_ar_ready_o, m0_r_valid_o, m0_r_ready;
    logic [31:0] m0_ar_addr, m0_r_data_o;
    logic [2:0]  m0_ar_port;
    logic [1:0]  m0_r_resp_o;
    logic        m1_ar_valid, m1_ar_ready_o, m1_r_valid_o, m1_r_ready;
    logic [31:0] m1_ar_addr, m1_r_data_o;
    logic [2:0]  m1_ar_port;
    logic [1:0]  m1_r_resp_o;
    logic        s_ar_valid_o, s_ar_ready, s_r_valid, s_r_ready_o;
    logic [31:0] s_ar_addr_o, s_r_data;
    logic [2:0]  s_ar_port_o;
    logic [1:0]  s_r_resp;

    always #5 aclk = ~aclk;

    ysyx_23060077_riscv_axi_rd_arbiter dut (
        .aclk(aclk), .areset_n(areset_n),
        .m0_ar_valid_i(m0_ar_valid), .m0_ar_ready_o(m0_ar_ready_o),
        .m0_ar_addr_i(m0_ar_addr), .m0_ar_port_i(m0_ar_port),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready),
        .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
        .m1_ar_valid_i(m1_ar_valid), .m1_ar_ready_o(m1_ar_ready_o),
        .m1_ar_addr_i(m1_ar_addr), .m1_ar_port_i(m1_ar_port),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready),
        .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready),
        .s_ar_addr_o(s_ar_addr_o), .s_ar_port_o(s_ar_port_o),
        .s_r_valid_i(s_r_valid), .s_r_ready_o(s_r_ready_o),
        .s_r_data_i(s_r_data), .s_r_resp_i(s_r_resp)
    );

    logic [108:0] all_outs;
    assign all_outs = {m0_ar_ready_o, m0_r_valid_o, m0_r_data_o, m0_r_resp_o,
                       m1_ar_ready_o, m1_r_valid_o, m1_r_data_o, m1_r_resp_o,
                       s_ar_valid_o, s_ar_addr_o, s_ar_port_o, s_r_ready_o};

    typedef struct packed {
        logic        mst;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        step();
        areset_n = 1'b1;
    endtask

    // One full transaction starting in an IDLE cycle with ar_valid already driven
    task automatic txn(input logic em, input logic [31:0] eaddr, input logic [2:0] eport,
                       input logic [31:0] rdata, input logic [1:0] rresp,
                       input int ar_stall, input int r_stall,
                       input logic keep0, input logic keep1, input logic late1);
        exp_t e;
        #1;
        chk("idle_ar_ready0", m0_ar_ready_o, em == 1'b0);
        chk("idle_ar_ready1", m1_ar_ready_o, em == 1'b1);
        chk("idle_s_ar_valid", s_ar_valid_o, 1'b0);
        step();
        m0_ar_valid = keep0;
        m1_ar_valid = keep1;
        s_ar_ready  = 1'b0;
        #1;
        for (int i = 0; i < ar_stall; i++) begin
            chk("stall_s_ar_valid", s_ar_valid_o, 1'b1);
            chk("stall_ar_ready", {m0_ar_ready_o, m1_ar_ready_o}, 2'b00);
            step();
            #1;
        end
        s_ar_ready = 1'b1;
        #1;
        chk("addr_s_ar_valid", s_ar_valid_o, 1'b1);
        chk("addr_s_ar_addr", s_ar_addr_o, eaddr);
        chk("addr_s_ar_port", s_ar_port_o, eport);
        chk("addr_ar_ready", {m0_ar_ready_o, m1_ar_ready_o}, 2'b00);
        step();
        s_ar_ready = 1'b0;
        if (late1) m1_ar_valid = 1'b1;
        s_r_valid = 1'b1;
        s_r_data  = rdata;
        s_r_resp  = rresp;
        e.mst  = em;
        e.data = rdata;
        e.resp = rresp;
        exp_q.push_back(e);
        m0_r_ready = em;
        m1_r_ready = ~em;
        #1;
        for (int i = 0; i < r_stall; i++) begin
            chk("rstall_s_r_ready", s_r_ready_o, 1'b0);
            chk("rstall_r_valid", {m1_r_valid_o, m0_r_valid_o}, em ? 2'b10 : 2'b01);
            chk("rstall_s_ar_valid", s_ar_valid_o, 1'b0);
            step();
            #1;
        end
        m0_r_ready = ~em;
        m1_r_ready = em;
        #1;
        chk("data_s_r_ready", s_r_ready_o, 1'b1);
        chk("data_ar_ready", {m0_ar_ready_o, m1_ar_ready_o}, 2'b00);
        chk("data_q_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.mst) begin
                chk("r_valid1", m1_r_valid_o, 1'b1);
                chk("r_data1", m1_r_data_o, e.data);
                chk("r_resp1", m1_r_resp_o, e.resp);
                chk("other0_quiet", {m0_r_valid_o, m0_r_data_o, m0_r_resp_o}, 35'd0);
            end else begin
                chk("r_valid0", m0_r_valid_o, 1'b1);
                chk("r_data0", m0_r_data_o, e.data);
                chk("r_resp0", m0_r_resp_o, e.resp);
                chk("other1_quiet", {m1_r_valid_o, m1_r_data_o, m1_r_resp_o}, 35'd0);
            end
        end
        step();
        s_r_valid  = 1'b0;
        s_r_data   = 32'd0;
        s_r_resp   = 2'd0;
        m0_r_ready = 1'b0;
        m1_r_ready = 1'b0;
    endtask

    initial begin
        areset_n = 1'b0;
        m0_ar_valid = 1'b1; m0_ar_addr = 32'h8000_0000; m0_ar_port = 3'd1; m0_r_ready = 1'b0;
        m1_ar_valid = 1'b1; m1_ar_addr = 32'h8000_1000; m1_ar_port = 3'd5; m1_r_ready = 1'b0;
        s_ar_ready = 1'b0; s_r_valid = 1'b1; s_r_data = 32'hFFFF_FFFF; s_r_resp = 2'd3;
        #1;
        chk("in_reset_outs", all_outs, 109'd0);
        step();
        step();
        chk("in_reset_outs2", all_outs, 109'd0);
        m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
        s_r_valid = 1'b0; s_r_data = 32'd0; s_r_resp = 2'd0;
        areset_n = 1'b1;
        #1;
        chk("post_reset_outs", all_outs, 109'd0);
        step();
        #1;
        chk("idle_no_req_outs", all_outs, 109'd0);

        // single uncontended m0 read
        m0_ar_valid = 1'b1;
        txn(1'b0, 32'h8000_0000, 3'd1, 32'hDEAD_BEEF, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // ties after reset alternate starting with m0
        do_reset();
        m0_ar_valid = 1'b1; m1_ar_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k[0]) txn(1'b1, 32'h8000_1000, 3'd5, 32'h1000 + k, 2'd0, 0, 0, k != 5, k != 5, 1'b0);
            else      txn(1'b0, 32'h8000_0000, 3'd1, 32'h2000 + k, 2'd0, 0, 0, 1'b1, 1'b1, 1'b0);
        end

        // late requester waits for m0's R handshake
        m0_ar_addr = 32'h8000_2000;
        m1_ar_addr = 32'h8000_3000;
        m0_ar_valid = 1'b1;
        txn(1'b0, 32'h8000_2000, 3'd1, 32'h0000_0A0A, 2'd0, 0, 0, 1'b0, 1'b0, 1'b1);
        txn(1'b1, 32'h8000_3000, 3'd5, 32'h0000_0B0B, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("m1_ready_single_pulse", m1_ar_ready_o, 1'b0);

        // address and data backpressure
        m0_ar_valid = 1'b1;
        txn(1'b0, 32'h8000_2000, 3'd1, 32'hCAFE_F00D, 2'd1, 5, 3, 1'b0, 1'b0, 1'b0);

        // error response passes through to m1
        m1_ar_valid = 1'b1;
        txn(1'b1, 32'h8000_3000, 3'd5, 32'h0000_1234, 2'b10, 0, 0, 1'b0, 1'b0, 1'b0);

        // reset while in ADDR, then tie must go to m0
        m0_ar_valid = 1'b1;
        step();
        m0_ar_valid = 1'b0;
        #1;
        chk("pre_rst_addr_valid", s_ar_valid_o, 1'b1);
        areset_n = 1'b0;
        #1;
        chk("rst_in_addr_outs", all_outs, 109'd0);
        step();
        areset_n = 1'b1;
        #1;
        chk("after_rst_addr_outs", all_outs, 109'd0);
        m0_ar_valid = 1'b1; m1_ar_valid = 1'b1;
        txn(1'b0, 32'h8000_2000, 3'd1, 32'h5555_AAAA, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // reset while in DATA with a beat pending; beat must not leak out
        m0_ar_valid = 1'b1;
        step();
        m0_ar_valid = 1'b0;
        s_ar_ready = 1'b1;
        step();
        s_ar_ready = 1'b0;
        s_r_valid = 1'b1; s_r_data = 32'h7777_8888; m0_r_ready = 1'b0;
        #1;
        chk("pre_rst_data_valid", m0_r_valid_o, 1'b1);
        areset_n = 1'b0;
        #1;
        chk("rst_in_data_outs", all_outs, 109'd0);
        step();
        areset_n = 1'b1;
        m0_r_ready = 1'b1;
        #1;
        chk("after_rst_data_outs", all_outs, 109'd0);
        s_r_valid = 1'b0; s_r_data = 32'd0; m0_r_ready = 1'b0;
        m0_ar_valid = 1'b1; m1_ar_valid = 1'b1;
        txn(1'b0, 32'h8000_2000, 3'd1, 32'h0BAD_F00D, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
